// File: rtl/qam16_pkg.sv
// ============================================================================
// Module      : qam16_pkg
// Description : Shared QAM16 constants, Gray level map and symbol slicer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qam16_pkg;

    localparam int SPS_DEFAULT = 4;

    typedef logic signed [3:0] sample_t;

    localparam sample_t LVL_M3 = -4'sd3;
    localparam sample_t LVL_M1 = -4'sd1;
    localparam sample_t LVL_P1 = 4'sd1;
    localparam sample_t LVL_P3 = 4'sd3;

    // Gray ordering along each rail: adjacent levels differ in one bit.
    typedef enum logic [1:0] {
        GRAY_M3 = 2'b00,
        GRAY_M1 = 2'b01,
        GRAY_P1 = 2'b11,
        GRAY_P3 = 2'b10
    } gray_sym_t;

    function automatic int acc_width(input int sps);
        return $clog2(3 * sps + 1) + 1;
    endfunction

    function automatic sample_t gray_map(input logic [1:0] bits);
        sample_t lvl;
        lvl = LVL_M3;
        case (bits)
            GRAY_M3: lvl = LVL_M3;
            GRAY_M1: lvl = LVL_M1;
            GRAY_P1: lvl = LVL_P1;
            GRAY_P3: lvl = LVL_P3;
            default: lvl = LVL_M3;
        endcase
        return lvl;
    endfunction

    // Decision thresholds sit midway between the integrated levels (+/-2*SPS and 0).
    function automatic logic [1:0] slice(input int sum, input int sps);
        logic [1:0] bits;
        if (sum >= 2 * sps) begin
            bits = GRAY_P3;
        end else if (sum >= 0) begin
            bits = GRAY_P1;
        end else if (sum >= -2 * sps) begin
            bits = GRAY_M1;
        end else begin
            bits = GRAY_M3;
        end
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qam16_demod.sv
// ============================================================================
// Module      : qam16_demod
// Description : Integrate-and-dump QAM16 demodulator for both rails with slicer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qam16_demod
    import qam16_pkg::*;
#(
    parameter int SPS = SPS_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(SPS)-1:0]     phase,
    input  logic signed [3:0]          i_sample,
    input  logic signed [3:0]          q_sample,
    output logic [3:0]                 og_data
);

    localparam int                  PW         = $clog2(SPS);
    localparam int                  ACC_W      = acc_width(SPS);
    localparam logic [PW-1:0]       PHASE_LAST = PW'(SPS - 1);

    logic [PW-1:0]           r_rx_phase;
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic [3:0]              r_og_data;

    logic signed [ACC_W-1:0] w_samp_i;
    logic signed [ACC_W-1:0] w_samp_q;
    logic signed [ACC_W-1:0] w_sum_i;
    logic signed [ACC_W-1:0] w_sum_q;
    logic [1:0]              w_slice_i;
    logic [1:0]              w_slice_q;

    assign w_samp_i  = ACC_W'(i_sample);
    assign w_samp_q  = ACC_W'(q_sample);
    assign w_sum_i   = r_acc_i + w_samp_i;
    assign w_sum_q   = r_acc_q + w_samp_q;
    assign w_slice_i = slice(int'(w_sum_i), SPS);
    assign w_slice_q = slice(int'(w_sum_q), SPS);

    // Samples lag the TX phase by one clock, so the delayed phase indexes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_phase <= '0;
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_og_data  <= '0;
        end else begin
            r_rx_phase <= phase;
            if (r_rx_phase == '0) begin
                r_acc_i <= w_samp_i;
                r_acc_q <= w_samp_q;
            end else begin
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
            end
            if (r_rx_phase == PHASE_LAST) begin
                r_og_data <= {w_slice_i, w_slice_q};
            end
        end
    end

    assign og_data = r_og_data;

endmodule

`default_nettype wire

// File: rtl/top_rx.sv
// ============================================================================
// Module      : top_rx
// Description : QAM16 loopback: symbol counter, Gray mapper, upsampler, demod.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_rx
    import qam16_pkg::*;
#(
    parameter int SPS = SPS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [3:0]        counter_v,
    output logic signed [3:0] i_up_v,
    output logic signed [3:0] q_up_v,
    output logic [3:0]        og_data
);

    localparam int            PW         = $clog2(SPS);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SPS - 1);

    logic [PW-1:0] r_phase;
    logic [3:0]    r_counter;
    sample_t       r_i_up;
    sample_t       r_q_up;

    // Holding the mapper output every clock is what performs the rectangular upsampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase   <= '0;
            r_counter <= '0;
            r_i_up    <= '0;
            r_q_up    <= '0;
        end else begin
            if (r_phase == PHASE_LAST) begin
                r_phase   <= '0;
                r_counter <= r_counter + 4'd1;
            end else begin
                r_phase   <= r_phase + PW'(1);
            end
            r_i_up <= gray_map(r_counter[3:2]);
            r_q_up <= gray_map(r_counter[1:0]);
        end
    end

    qam16_demod #(
        .SPS (SPS)
    ) u_demod (
        .clk      (clk),
        .reset    (reset),
        .phase    (r_phase),
        .i_sample (r_i_up),
        .q_sample (r_q_up),
        .og_data  (og_data)
    );

    assign counter_v = r_counter;
    assign i_up_v    = r_i_up;
    assign q_up_v    = r_q_up;

endmodule

`default_nettype wire

// File: tb/tb_top_rx.sv
// ============================================================================
// Module      : tb_top_rx
// Description : Scoreboard bench for top_rx at SPS = 4, 2 and 8 with random resets.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_top_rx;

    localparam int N_DUT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [3:0]        cnt_v [N_DUT];
    logic signed [3:0] i_v   [N_DUT];
    logic signed [3:0] q_v   [N_DUT];
    logic [3:0]        og_v  [N_DUT];

    int total = 0;
    int bad   = 0;
    int n_edges = 0;

    typedef struct {
        int cnt;
        int i;
        int q;
        int og;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    top_rx #(.SPS(4)) u_sps4 (
        .clk(clk), .reset(reset), .counter_v(cnt_v[0]),
        .i_up_v(i_v[0]), .q_up_v(q_v[0]), .og_data(og_v[0])
    );
    top_rx #(.SPS(2)) u_sps2 (
        .clk(clk), .reset(reset), .counter_v(cnt_v[1]),
        .i_up_v(i_v[1]), .q_up_v(q_v[1]), .og_data(og_v[1])
    );
    top_rx #(.SPS(8)) u_sps8 (
        .clk(clk), .reset(reset), .counter_v(cnt_v[2]),
        .i_up_v(i_v[2]), .q_up_v(q_v[2]), .og_data(og_v[2])
    );

    function automatic int sps_of(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int gray_lvl(input int bits2);
        case (bits2)
            0:       return -3;
            1:       return -1;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    // Source symbol after n edges since release.
    function automatic int sym_at(input int sps, input int n);
        if (n < 0) return 0;
        return (n / sps) % 16;
    endfunction

    function automatic exp_t model(input int k, input int n);
        exp_t e;
        int   s;
        s     = sps_of(k);
        e.cnt = sym_at(s, n);
        e.i   = (n == 0) ? 0 : gray_lvl(sym_at(s, n - 1) / 4);
        e.q   = (n == 0) ? 0 : gray_lvl(sym_at(s, n - 1) % 4);
        e.og  = (n < s + 1) ? 0 : sym_at(s, n - s - 1);
        return e;
    endfunction

    task automatic check(input string name, input int k, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s sps=%0d t=%0t got=%0d want=%0d", name, sps_of(k), $time, act, want);
        end
    endtask

    // Driver side of the scoreboard: decide expectations shortly after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (reset) n_edges = 0;
            else       n_edges++;
            for (int k = 0; k < N_DUT; k++) exp_q.push_back(model(k, n_edges));
        end
    end

    // Monitor: compare DUT outputs on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < N_DUT; k++) begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    check("queue_underflow", k, 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("counter_v", k, int'(cnt_v[k]), e.cnt);
                    check("i_up_v",    k, int'(i_v[k]),   e.i);
                    check("q_up_v",    k, int'(q_v[k]),   e.q);
                    check("og_data",   k, int'(og_v[k]),  e.og);
                end
            end
        end
    end

    task automatic run_segment(input int len);
        repeat (len) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check("async_clr_counter", k, int'(cnt_v[k]), 0);
            check("async_clr_i",       k, int'(i_v[k]),   0);
            check("async_clr_q",       k, int'(q_v[k]),   0);
            check("async_clr_og",      k, int'(og_v[k]),  0);
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #7 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #7 reset = 1'b0;
        // 102 edges: past both wraps at SPS=4 and ends mid-symbol at phase 2.
        run_segment(102);
        run_segment(150 + $urandom_range(0, 60));
        repeat (2) run_segment($urandom_range(5, 120));
        repeat (3) @(posedge clk);
        #6;
        check("queue_drained", 0, exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
